fft_bfly_writeback: RTL and testbench
=====================================

# fft_bfly_writeback

Radix-2 butterfly and write-back stage of the in-place sequential FFT. It consumes the operand pairs that the per-stage address generator reads from the sample RAM: the top address, then the bottom address (top + span), with the twiddle angle issued alongside the top address. It computes X = (A + W·B)/2 and Y = (A − W·B)/2 and writes both results back to the same two RAM addresses. It signals the controller once the final write of the stage has been issued.

## Interface
Parameters:
- N, 16: FFT points.
- SIZE, 4: address width, log2(N).
- DW, 16: signed width of each real/imag sample component.
- TW, 16: signed twiddle width, format Q1.(TW-2); 1.0 = 2^(TW-2).

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en_rd  in  1  read issue strobe from the address generator; one address per cycle while high.
- rd_ptr  in  SIZE  address issued this cycle.
- issue_done  in  1  one-cycle pulse, the cycle after the last address of the stage is issued.
- rd_re, rd_im  in  DW  RAM read data; valid 1 cycle after the address.
- tw_cos, tw_sin  in  TW  twiddle ROM data; valid 1 cycle after the top address.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  SIZE  write address.
- wr_re, wr_im  out  DW  write data.
- stage_done  out  1  one-cycle pulse, the cycle after the final write of the stage.
- busy  out  1  high while any issued address has not yet been written back.
- pair_err  out  1  sticky protocol error flag.

## Operation
- Phase bit: cleared while en_rd=0; toggles every cycle en_rd=1. Phase 0 marks a top address, phase 1 a bottom address.
- Capture registers, one cycle after issue:
  - after a top issue: capture A = rd_*, plus c = tw_cos and s = tw_sin;
  - after a bottom issue: capture B.
- Twiddle is W = c − j·s.
- WB product:
  - WBre = (Bre·c + Bim·s) >>> (TW-2);
  - WBim = (Bim·c − Bre·s) >>> (TW-2);
  - full-precision products; arithmetic shift (truncation toward −inf); WB is kept in DW+2 bits.
- Sum/difference:
  - X = (A + WB) >>> 1 and Y = (A − WB) >>> 1, computed in DW+3 bits;
  - each component then saturates to [−2^(DW-1), 2^(DW-1)−1].
- Write order: X goes to the top address, then Y to the bottom address on the next cycle. Addresses are the issued rd_ptr values, delayed.
- Incomplete pair: en_rd falls while phase=1 (top issued, no bottom).
  - Discard the pair; no writes for it.
  - Set pair_err; it clears only on reset.
- No internal stage state. Any number of pairs per stage is accepted; twiddle and address patterns are entirely upstream's responsibility.

## Timing
- Uniform write-back latency: an address issued in cycle t is written in cycle t+5, with wr_en=1 and wr_addr equal to that address.
- Pipeline for a top address at T:
  - A/W captured end T+1;
  - B captured end T+2;
  - products registered end T+3;
  - X/Y registered end T+4;
  - X written at T+5;
  - Y held and written at T+6.
- Back-to-back pairs (top every 2 cycles) produce continuous wr_en with no stall. The block has no backpressure.
- stage_done = issue_done delayed 5 cycles. This is exactly the cycle after the last write.
- busy: high from the first en_rd until the cycle of stage_done, inclusive.
- Reset values: wr_en=0, wr_addr=0, wr_re=0, wr_im=0, stage_done=0, busy=0, pair_err=0. All pipeline valid bits and the phase bit are 0.
- Reset mid-stage flushes the pipeline: no write and no stage_done is emitted for in-flight pairs after rst_n is released.
- issue_done arriving while en_rd=1 is legal. It is simply delayed; writes still complete.

## Test plan
Default parameters (N=16, SIZE=4, DW=16, TW=16) for all scenarios:
- Unit twiddle, single pair:
  - stimulus: top addr 2, bottom addr 6, A=(1000,0), B=(200,0), W=(16384,0);
  - required: wr addr 2 = (600,0) at issue+5; wr addr 6 = (400,0) the next cycle.
- −j twiddle:
  - stimulus: c=0, s=16384, A=(1000,0), B=(200,0);
  - required: X=(500,−100), Y=(500,100).
- Full stage:
  - stimulus: 8 back-to-back pairs of a stride-4 stage.
  - required:
    - 16 consecutive wr_en cycles;
    - wr_addr sequence equals the issued sequence delayed 5;
    - stage_done 1 cycle after the last write;
    - busy low afterwards.
- Rounding and saturation:
  - stimulus 1: A=(−3,0), B=0, W=1.
  - required 1: X=(−2,0), Y=(−2,0).
  - stimulus 2: A=(32767,0), B=(32767,32767), c=s=16384.
  - required 2: Xre=32767 (saturated), Yre=−16384.
- Incomplete pair:
  - stimulus: en_rd high for exactly 1 cycle.
  - required: no wr_en at any time; pair_err=1 from the following cycle until reset.
- Reset mid-stage:
  - stimulus: assert rst_n low 3 cycles after the first issue, then release.
  - required: all outputs 0 immediately; no wr_en or stage_done afterwards until new issues arrive.

Source files
------------

// File: rtl/fft_bfly_writeback.sv
// fft_bfly_writeback
//   Radix-2 butterfly plus write-back stage of the in-place sequential FFT.
//   Operand pairs arrive as issued RAM reads (top address, then bottom address
//   the next cycle). The twiddle is presented alongside the top read data.
//   X = (A + W*B)/2 goes back to the top address and Y = (A - W*B)/2 goes back
//   to the bottom address. Every issued address is written exactly 5 cycles
//   after it was issued.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en_rd, rd_ptr     address issue strobe and the address issued this cycle
//   issue_done        pulse the cycle after the last issue of a stage
//   rd_re, rd_im      RAM read data, valid 1 cycle after its address
//   tw_cos, tw_sin    twiddle (Q1.(TW-2)), valid 1 cycle after a top address
//   wr_en, wr_addr    RAM write strobe and address
//   wr_re, wr_im      RAM write data
//   stage_done        pulse the cycle after the final write of the stage
//   busy              issued addresses are still awaiting write-back
//   pair_err          sticky: a top address was issued without its bottom
module fft_bfly_writeback #(
   parameter int N    = 16,
   parameter int SIZE = 4,
   parameter int DW   = 16,
   parameter int TW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_rd,
   input  logic [SIZE-1:0] rd_ptr,
   input  logic            issue_done,
   input  logic [DW-1:0]   rd_re,
   input  logic [DW-1:0]   rd_im,
   input  logic [TW-1:0]   tw_cos,
   input  logic [TW-1:0]   tw_sin,
   output logic            wr_en,
   output logic [SIZE-1:0] wr_addr,
   output logic [DW-1:0]   wr_re,
   output logic [DW-1:0]   wr_im,
   output logic            stage_done,
   output logic            busy,
   output logic            pair_err
);

   localparam int PW = DW + TW + 1;   // full-precision sum of two products
   localparam int WW = DW + 2;        // W*B after the Q-format shift
   localparam int SW = DW + 3;        // sum/difference width
   localparam logic [SIZE-1:0] ADDR_MASK = SIZE'(N - 1);
   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DW - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[DW-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[DW-1:0];
      else
         return v[DW-1:0];
   endfunction

   // issue tracking
   logic                   phase_reg;
   logic                   iss_top_reg, iss_bot_reg;
   logic [SIZE-1:0]        iss_addr_reg;
   // operand capture
   logic signed [DW-1:0]   a_re_reg, a_im_reg, b_re_reg, b_im_reg;
   logic signed [TW-1:0]   c_reg, s_reg;
   logic [SIZE-1:0]        top_addr_reg, bot_addr_reg;
   logic                   bv_reg;
   // product stage
   logic signed [WW-1:0]   wb_re_reg, wb_im_reg;
   logic signed [DW-1:0]   pa_re_reg, pa_im_reg;
   logic [SIZE-1:0]        p_top_reg, p_bot_reg;
   logic                   pv_reg;
   // Y waits one cycle behind X
   logic [DW-1:0]          y_re_reg, y_im_reg;
   logic [SIZE-1:0]        y_addr_reg;
   logic                   y_pend_reg;
   logic [4:0]             done_sr_reg;
   logic                   busy_reg, err_reg;

   logic signed [PW-1:0]   wb_re_full, wb_im_full;
   logic signed [WW-1:0]   wb_re_next, wb_im_next;
   logic signed [SW-1:0]   x_re_sum, x_im_sum, y_re_sum, y_im_sum;

   // W = c - j*s, so W*B = (Bre*c + Bim*s) + j(Bim*c - Bre*s)
   always_comb begin
      wb_re_full = PW'(b_re_reg) * PW'(c_reg) + PW'(b_im_reg) * PW'(s_reg);
      wb_im_full = PW'(b_im_reg) * PW'(c_reg) - PW'(b_re_reg) * PW'(s_reg);
      wb_re_next = WW'(wb_re_full >>> (TW - 2));
      wb_im_next = WW'(wb_im_full >>> (TW - 2));
      x_re_sum   = (SW'(pa_re_reg) + SW'(wb_re_reg)) >>> 1;
      x_im_sum   = (SW'(pa_im_reg) + SW'(wb_im_reg)) >>> 1;
      y_re_sum   = (SW'(pa_re_reg) - SW'(wb_re_reg)) >>> 1;
      y_im_sum   = (SW'(pa_im_reg) - SW'(wb_im_reg)) >>> 1;
   end

   // Issue tracking and operand capture. A top issued without a bottom never
   // raises bv_reg, so the orphaned operands are simply overwritten later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg    <= 1'b0;
         iss_top_reg  <= 1'b0;
         iss_bot_reg  <= 1'b0;
         iss_addr_reg <= '0;
         a_re_reg     <= '0;
         a_im_reg     <= '0;
         c_reg        <= '0;
         s_reg        <= '0;
         top_addr_reg <= '0;
         b_re_reg     <= '0;
         b_im_reg     <= '0;
         bot_addr_reg <= '0;
         bv_reg       <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         phase_reg    <= en_rd ? ~phase_reg : 1'b0;
         iss_top_reg  <= en_rd & ~phase_reg;
         iss_bot_reg  <= en_rd & phase_reg;
         iss_addr_reg <= rd_ptr;
         if (!en_rd && phase_reg)
            err_reg <= 1'b1;
         if (iss_top_reg) begin
            a_re_reg     <= $signed(rd_re);
            a_im_reg     <= $signed(rd_im);
            c_reg        <= $signed(tw_cos);
            s_reg        <= $signed(tw_sin);
            top_addr_reg <= iss_addr_reg;
         end
         bv_reg <= iss_bot_reg;
         if (iss_bot_reg) begin
            b_re_reg     <= $signed(rd_re);
            b_im_reg     <= $signed(rd_im);
            bot_addr_reg <= iss_addr_reg;
         end
      end
   end

   // Product stage. A still holds this pair during this cycle (the next top
   // is captured at the same edge), so it is carried forward here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_re_reg <= '0;
         wb_im_reg <= '0;
         pa_re_reg <= '0;
         pa_im_reg <= '0;
         p_top_reg <= '0;
         p_bot_reg <= '0;
         pv_reg    <= 1'b0;
      end else begin
         pv_reg <= bv_reg;
         if (bv_reg) begin
            wb_re_reg <= wb_re_next;
            wb_im_reg <= wb_im_next;
            pa_re_reg <= a_re_reg;
            pa_im_reg <= a_im_reg;
            p_top_reg <= top_addr_reg;
            p_bot_reg <= bot_addr_reg;
         end
      end
   end

   // Write-back: X leaves immediately, Y follows next cycle. Pairs are at
   // least two cycles apart, so a new X never collides with a pending Y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_re      <= '0;
         wr_im      <= '0;
         y_re_reg   <= '0;
         y_im_reg   <= '0;
         y_addr_reg <= '0;
         y_pend_reg <= 1'b0;
      end else begin
         y_pend_reg <= pv_reg;
         if (pv_reg) begin
            wr_en      <= 1'b1;
            wr_addr    <= p_top_reg & ADDR_MASK;
            wr_re      <= sat(x_re_sum);
            wr_im      <= sat(x_im_sum);
            y_re_reg   <= sat(y_re_sum);
            y_im_reg   <= sat(y_im_sum);
            y_addr_reg <= p_bot_reg & ADDR_MASK;
         end else if (y_pend_reg) begin
            wr_en   <= 1'b1;
            wr_addr <= y_addr_reg;
            wr_re   <= y_re_reg;
            wr_im   <= y_im_reg;
         end else begin
            wr_en <= 1'b0;
         end
      end
   end

   // issue_done trails the last issue by one cycle; five more cycles lands
   // one cycle after that address's write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_sr_reg <= '0;
         busy_reg    <= 1'b0;
      end else begin
         done_sr_reg <= {done_sr_reg[3:0], issue_done};
         if (en_rd)
            busy_reg <= 1'b1;
         else if (done_sr_reg[4])
            busy_reg <= 1'b0;
      end
   end

   assign stage_done = done_sr_reg[4];
   assign busy       = busy_reg;
   assign pair_err   = err_reg;

endmodule

// File: tb/tb_fft_bfly_writeback.sv
// Scoreboard bench for fft_bfly_writeback: the stimulus pushes hand-computed
// writes and stage_done cycles into queues, a negedge monitor pops and checks.
module tb_fft_bfly_writeback;
   localparam int N = 16, SIZE = 4, DW = 16, TW = 16;
   localparam logic [15:0] JUNK = 16'h5A5A;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en_rd;
   logic [SIZE-1:0] rd_ptr;
   logic            issue_done;
   logic [DW-1:0]   rd_re, rd_im;
   logic [TW-1:0]   tw_cos, tw_sin;
   logic            wr_en;
   logic [SIZE-1:0] wr_addr;
   logic [DW-1:0]   wr_re, wr_im;
   logic            stage_done, busy, pair_err;

   fft_bfly_writeback #(.N(N), .SIZE(SIZE), .DW(DW), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n), .en_rd(en_rd), .rd_ptr(rd_ptr),
      .issue_done(issue_done), .rd_re(rd_re), .rd_im(rd_im),
      .tw_cos(tw_cos), .tw_sin(tw_sin), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_re(wr_re), .wr_im(wr_im), .stage_done(stage_done), .busy(busy),
      .pair_err(pair_err)
   );

   always #5 clk = ~clk;

   int cycle_cnt = 0;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   typedef struct {
      int cyc;
      int addr;
      int re;
      int im;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   run_len  = 0;
   int   last_run = 0;

   int v_top[8], v_bot[8], v_are[8], v_aim[8], v_bre[8], v_bim[8];
   int v_c[8], v_s[8], v_xre[8], v_xim[8], v_yre[8], v_yim[8];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (wr_en) begin
         $display("write cyc=%0d addr=%0d re=%0d im=%0d", cycle_cnt, wr_addr,
                  int'($signed(wr_re)), int'($signed(wr_im)));
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got write to addr %0d, expected none (cycle %0d)",
                     wr_addr, cycle_cnt);
         end else begin
            e = exp_q.pop_front();
            chk("wr_cycle", cycle_cnt, e.cyc);
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_re", int'($signed(wr_re)), e.re);
            chk("wr_im", int'($signed(wr_im)), e.im);
         end
         run_len++;
      end else begin
         if (run_len > 0) last_run = run_len;
         run_len = 0;
      end
      if (stage_done) begin
         $display("stage_done cyc=%0d busy=%0d", cycle_cnt, busy);
         if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_stage_done: got pulse, expected none (cycle %0d)", cycle_cnt);
         end else begin
            chk("stage_done_cycle", cycle_cnt, done_q.pop_front());
            chk("busy_at_stage_done", int'(busy), 1);
         end
      end
   end

   task automatic setv(input int i, top, bot, are, aim, bre, bim, c, s,
                       xre, xim, yre, yim);
      v_top[i] = top; v_bot[i] = bot;
      v_are[i] = are; v_aim[i] = aim; v_bre[i] = bre; v_bim[i] = bim;
      v_c[i] = c; v_s[i] = s;
      v_xre[i] = xre; v_xim[i] = xim; v_yre[i] = yre; v_yim[i] = yim;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         en_rd = 1'b0; rd_ptr = '0; issue_done = 1'b0;
         rd_re = JUNK; rd_im = JUNK; tw_cos = JUNK; tw_sin = JUNK;
      end
   endtask

   // Issues n back-to-back pairs from the vector table, then issue_done.
   task automatic run_seq(input int n);
      exp_t e;
      int   j;
      for (int k = 0; k <= 2 * n; k++) begin
         @(posedge clk); #1;
         en_rd      = (k < 2 * n);
         issue_done = (k == 2 * n);
         rd_ptr     = '0;
         if (k < 2 * n) rd_ptr = (k % 2 == 0) ? 4'(v_top[k / 2]) : 4'(v_bot[k / 2]);
         rd_re = JUNK; rd_im = JUNK; tw_cos = JUNK; tw_sin = JUNK;
         if (k > 0) begin
            j = (k - 1) / 2;
            if ((k - 1) % 2 == 0) begin
               rd_re = 16'(v_are[j]); rd_im = 16'(v_aim[j]);
               tw_cos = 16'(v_c[j]); tw_sin = 16'(v_s[j]);
            end else begin
               rd_re = 16'(v_bre[j]); rd_im = 16'(v_bim[j]);
            end
         end
         if (k < 2 * n && k % 2 == 0) begin
            e.cyc = cycle_cnt + 5; e.addr = v_top[k / 2];
            e.re = v_xre[k / 2]; e.im = v_xim[k / 2];
            exp_q.push_back(e);
            e.cyc = cycle_cnt + 6; e.addr = v_bot[k / 2];
            e.re = v_yre[k / 2]; e.im = v_yim[k / 2];
            exp_q.push_back(e);
         end
         if (k == 2 * n) done_q.push_back(cycle_cnt + 5);
      end
      idle(1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_re"}, int'(wr_re), 0);
      chk({tag, "_wr_im"}, int'(wr_im), 0);
      chk({tag, "_stage_done"}, int'(stage_done), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_pair_err"}, int'(pair_err), 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en_rd = 1'b0; rd_ptr = '0; issue_done = 1'b0;
      rd_re = JUNK; rd_im = JUNK; tw_cos = JUNK; tw_sin = JUNK;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // unit twiddle, single pair
      setv(0, 2, 6, 1000, 0, 200, 0, 16384, 0, 600, 0, 400, 0);
      run_seq(1);
      idle(10);
      chk("unit_pending", exp_q.size() + done_q.size(), 0);
      chk("unit_busy_after", int'(busy), 0);

      // -j twiddle
      setv(0, 3, 11, 1000, 0, 200, 0, 0, 16384, 500, -100, 500, 100);
      run_seq(1);
      idle(10);
      chk("negj_pending", exp_q.size() + done_q.size(), 0);

      // rounding toward -inf and saturation
      setv(0, 0, 8, -3, 0, 0, 0, 16384, 0, -2, 0, -2, 0);
      setv(1, 1, 9, 32767, 0, 32767, 32767, 16384, 16384, 32767, 0, -16384, 0);
      run_seq(2);
      idle(10);
      chk("round_sat_pending", exp_q.size() + done_q.size(), 0);

      // full stride-4 stage, 8 back-to-back pairs
      setv(0, 0, 4, 100, 20, 40, -10, 16384, 0, 70, 5, 30, 15);
      setv(1, 1, 5, -50, 60, 10, 10, 16384, 0, -20, 35, -30, 25);
      setv(2, 2, 6, 8, 8, 4, -4, 0, 16384, 2, 2, 6, 6);
      setv(3, 3, 7, 0, 0, -6, 2, 16384, 0, -3, 1, 3, -1);
      setv(4, 8, 12, 1000, -1000, 500, 500, 16384, 0, 750, -250, 250, -750);
      setv(5, 9, 13, 7, 0, 0, 0, 16384, 0, 3, 0, 3, 0);
      setv(6, 10, 14, -7, 3, 0, 0, 16384, 0, -4, 1, -4, 1);
      setv(7, 11, 15, 200, 100, 100, 200, 0, 16384, 200, 0, 0, 100);
      run_seq(8);
      chk("stage_busy_mid", int'(busy), 1);
      idle(10);
      chk("stage_wr_run_len", last_run, 16);
      chk("stage_pending", exp_q.size() + done_q.size(), 0);
      chk("stage_busy_after", int'(busy), 0);

      // incomplete pair: en_rd high for a single cycle
      @(posedge clk); #1;
      en_rd = 1'b1; rd_ptr = 4'd5;
      @(posedge clk); #1;
      en_rd = 1'b0; rd_ptr = '0;
      rd_re = 16'd1000; rd_im = 16'd0; tw_cos = 16'd16384; tw_sin = 16'd0;
      idle(1);
      chk("pair_err_set", int'(pair_err), 1);
      idle(8);
      chk("pair_err_sticky", int'(pair_err), 1);

      // reset three cycles after the first issue
      @(posedge clk); #1;
      en_rd = 1'b1; rd_ptr = 4'd0;
      @(posedge clk); #1;
      rd_ptr = 4'd4; rd_re = 16'd1000; rd_im = 16'd0; tw_cos = 16'd16384; tw_sin = 16'd0;
      @(posedge clk); #1;
      rd_ptr = 4'd1; rd_re = 16'd200; rd_im = 16'd0; issue_done = 1'b1;
      @(posedge clk); #1;
      en_rd = 1'b0; rd_ptr = '0; issue_done = 1'b0; rst_n = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(12);
      chk("post_reset_pair_err", int'(pair_err), 0);
      chk("post_reset_busy", int'(busy), 0);

      // recovery after reset
      setv(0, 7, 15, 1000, 0, 200, 0, 16384, 0, 600, 0, 400, 0);
      run_seq(1);
      idle(10);
      chk("recovery_pending", exp_q.size() + done_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
